// File: rtl/lsu_mem_stage_pkg.sv
// lsu_mem_stage_pkg: shared types and helpers for the rv32 memory-access stage
package lsu_mem_stage_pkg;

    typedef enum logic [1:0] {DB, DH, DW} dw_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;

    typedef struct packed {
        logic        load;
        logic        store;
        logic        sign;
        dw_t         dw;
        logic [1:0]  off;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic misaligned(dw_t dw, logic [1:0] off);
        return (dw == DH && off[0]) || (dw == DW && off != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// lsu_align: store lane steering/strobes and load shift/extend, shared by both paths
module lsu_align
    import lsu_mem_stage_pkg::*;
(
    input  logic [1:0]  dw,
    input  logic        sign,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  we,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [31:0] sh;

    assign sh = rdata >> {off, 3'b000};

    always_comb begin
        we         = dw == DB ? 4'b0001 << off : dw == DH ? 4'b0011 << off : 4'hF;
        lane_wdata = dw == DB ? {4{wdata[7:0]}} : dw == DH ? {2{wdata[15:0]}} : wdata;
        load_data  = dw == DB ? {{24{sign & sh[7]}}, sh[7:0]} :
                     dw == DH ? {{16{sign & sh[15]}}, sh[15:0]} : sh;
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store memory-access stage with alignment check, lane steering and timeout
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_load,
    input  logic          req_store,
    input  logic          req_sign,
    input  logic [1:0]    req_dw,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [4:0]    req_rd,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [4:0]    rsp_rd,
    output logic [31:0]   rsp_data,
    output logic          rsp_misalign,
    output logic          rsp_err
);

    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    lsu_state_t  state, state_n;
    lsu_req_t    req_in, req_q, sel;
    logic [CW-1:0] cnt;
    logic        accept, fault, timed_out, issue_n, hold, got, mis_n, err_n;
    logic [4:0]  rd_n;
    logic [31:0] data_n, lane_wdata, load_data;
    logic [3:0]  we;

    // load wins when both op bits are set
    assign req_in = '{load: req_load, store: req_store & ~req_load, sign: req_sign,
                      dw: dw_t'(req_dw), off: req_addr[1:0], rd: req_rd, wdata: req_wdata};
    assign accept = req_valid && req_ready && state == IDLE;
    assign fault = (req_in.load || req_in.store) && misaligned(req_in.dw, req_in.off);
    assign timed_out = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
    assign sel = state == IDLE ? req_in : req_q;

    lsu_align u_align (
        .dw        (sel.dw),
        .sign      (sel.sign),
        .off       (sel.off),
        .wdata     (sel.wdata),
        .rdata     (mem_rdata),
        .we        (we),
        .lane_wdata(lane_wdata),
        .load_data (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = (fault || !(req_in.load || req_in.store)) ? RESP : ISSUE;
            ISSUE:   state_n = sel.load ? WAIT : RESP;
            WAIT:    if (mem_rvalid || timed_out) state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // response fields are captured on entry to RESP and frozen until rsp_ready
    always_comb begin
        issue_n = state_n == ISSUE;
        hold    = state == RESP && state_n == RESP;
        got     = state == WAIT && mem_rvalid;
        rd_n    = hold ? rsp_rd : got ? sel.rd : 5'd0;
        data_n  = hold ? rsp_data : got ? load_data : 32'd0;
        mis_n   = hold ? rsp_misalign : state == IDLE && state_n == RESP && fault;
        err_n   = hold ? rsp_err : state == WAIT && state_n == RESP && !mem_rvalid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready    <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            rsp_valid    <= 1'b0;
            rsp_rd       <= '0;
            rsp_data     <= '0;
            rsp_misalign <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            req_ready    <= state_n == IDLE;
            mem_en       <= issue_n;
            mem_we       <= issue_n && sel.store ? we : 4'h0;
            mem_addr     <= issue_n ? {req_addr[AW-1:2], 2'b00} : '0;
            mem_wdata    <= issue_n && sel.store ? lane_wdata : 32'd0;
            rsp_valid    <= state_n == RESP;
            rsp_rd       <= rd_n;
            rsp_data     <= data_n;
            rsp_misalign <= mis_n;
            rsp_err      <= err_n;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            req_q <= req_in;
        cnt <= state == WAIT ? cnt + 1'b1 : '0;
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: randomized and directed checks of lsu_mem_stage against a byte-level model
module tb_lsu_mem_stage;
    import lsu_mem_stage_pkg::*;

    localparam int AW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0, rst = 1'b1;
    logic          req_valid = 0, req_ready, req_load = 0, req_store = 0, req_sign = 0;
    logic [1:0]    req_dw = 0;
    logic [AW-1:0] req_addr = 0;
    logic [31:0]   req_wdata = 0;
    logic [4:0]    req_rd = 0;
    logic          mem_en, mem_rvalid = 0, rsp_valid, rsp_ready = 0, rsp_misalign, rsp_err;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata = 0, rsp_data;
    logic [4:0]    rsp_rd;

    int n_pass = 0, n_total = 0, cyc = 0;

    int          o_acc, o_en_k, o_en_cnt, o_rsp_k;
    logic [3:0]  o_we;
    logic [31:0] o_addr, o_wdata, o_data;
    logic [4:0]  o_rd;
    logic        o_mis, o_err, o_stable, o_ready_low;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_mem_stage #(.AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .req_sign(req_sign), .req_dw(req_dw),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
        .rsp_misalign(rsp_misalign), .rsp_err(rsp_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference model: byte-level arithmetic on the access size
    function automatic logic [31:0] m_load(logic [31:0] word, int nb, logic sg, int off);
        longint v;
        v = longint'(word >> (8 * off));
        if (nb < 4) begin
            v = v % (longint'(1) << (8 * nb));
            if (sg && v >= (longint'(1) << (8 * nb - 1)))
                v = v - (longint'(1) << (8 * nb));
        end
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_we(int nb, int off);
        int m;
        m = ((1 << nb) - 1) << off;
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(logic [31:0] w, int nb);
        return nb == 1 ? (w & 32'hFF) * 32'h01010101 : nb == 2 ? (w & 32'hFFFF) * 32'h00010001 : w;
    endfunction

    // drives one op, emulates the memory (rvalid lat cycles after mem_en; lat<=0 = never) and records what the DUT did
    task automatic run_op(input logic l, s, sg, input logic [1:0] dw, input logic [31:0] addr, w,
                          input logic [4:0] rd, input logic [31:0] rdata, input int lat, input int hold);
        int g, rv_at;
        req_load = l; req_store = s; req_sign = sg; req_dw = dw;
        req_addr = addr; req_wdata = w; req_rd = rd; req_valid = 1'b1; mem_rdata = rdata;
        g = 0;
        while (!req_ready && g < 20) begin step(); g++; end
        o_acc = cyc;
        step();
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        req_dw = 2'($urandom_range(0, 2)); req_sign = 1'($urandom);
        o_en_k = -1; o_en_cnt = 0; o_rsp_k = -1; o_stable = 1'b1; o_ready_low = 1'b1;
        rv_at = -1;
        for (int k = 0; k < 60; k++) begin
            mem_rvalid = k == rv_at;
            if (mem_en) begin
                o_en_cnt++;
                if (o_en_k < 0) begin
                    o_en_k = k; o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata;
                    if (lat > 0) rv_at = k + lat;
                end
            end
            if (rsp_valid) begin
                if (o_rsp_k < 0) begin
                    o_rsp_k = k; o_rd = rsp_rd; o_data = rsp_data; o_mis = rsp_misalign; o_err = rsp_err;
                end else if ({rsp_rd, rsp_data, rsp_misalign, rsp_err} !== {o_rd, o_data, o_mis, o_err})
                    o_stable = 1'b0;
                if (req_ready) o_ready_low = 1'b0;
                rsp_ready = k >= o_rsp_k + hold;
                if (rsp_ready) begin
                    step();
                    rsp_ready = 1'b0;
                    break;
                end
            end
            step();
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_total++;
        if ({req_ready, mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_rd, rsp_data, rsp_misalign, rsp_err} !== '0)
            $display("FAIL reset_outputs: got ready=%b en=%b we=%h rsp_valid=%b data=%h, need all 0",
                     req_ready, mem_en, mem_we, rsp_valid, rsp_data);
        else n_pass++;
        rst = 1'b0;
        step();
        n_total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL reset_release: got ready=%b rsp_valid=%b, need 1 0", req_ready, rsp_valid);
        else n_pass++;
    endtask

    task automatic test_store();
        run_op(0, 1, 0, DW, 32'h100, 32'h0102F3F4, 5'd5, 32'h0, 1, 0);
        n_total++;
        if (o_en_k !== 0 || o_en_cnt !== 1 || o_we !== 4'hF || o_addr !== 32'h100 || o_wdata !== 32'h0102F3F4)
            $display("FAIL sw_issue: got en_k=%0d cnt=%0d we=%h addr=%h wdata=%h, need 0 1 f 00000100 0102f3f4",
                     o_en_k, o_en_cnt, o_we, o_addr, o_wdata);
        else n_pass++;
        n_total++;
        if (o_rsp_k !== 1 || o_rd !== 5'd0 || o_data !== 32'd0 || o_mis !== 1'b0 || o_err !== 1'b0)
            $display("FAIL sw_rsp: got rsp_k=%0d rd=%0d data=%h mis=%b err=%b, need 1 0 0 0 0",
                     o_rsp_k, o_rd, o_data, o_mis, o_err);
        else n_pass++;
        run_op(0, 1, 0, DB, 32'h102, 32'h000000AB, 5'd6, 32'h0, 1, 0);
        n_total++;
        if (o_we !== 4'b0100 || o_wdata !== 32'hABABABAB || o_addr !== 32'h100 || o_rsp_k !== 1)
            $display("FAIL sb_lanes: got we=%b wdata=%h addr=%h rsp_k=%0d, need 0100 abababab 00000100 1",
                     o_we, o_wdata, o_addr, o_rsp_k);
        else n_pass++;
    endtask

    task automatic test_loads();
        logic [31:0] tbl_addr [7] = '{32'h100, 32'h100, 32'h103, 32'h100, 32'h100, 32'h102, 32'h100};
        logic [1:0]  tbl_dw   [7] = '{DB, DB, DB, DH, DH, DH, DW};
        logic        tbl_sg   [7] = '{1, 0, 1, 1, 0, 1, 1};
        logic [31:0] tbl_exp  [7] = '{32'hFFFFFFF4, 32'h000000F4, 32'h00000001, 32'hFFFFF3F4,
                                      32'h0000F3F4, 32'h00000102, 32'h0102F3F4};
        for (int i = 0; i < 7; i++) begin
            run_op(1, 0, tbl_sg[i], tbl_dw[i], tbl_addr[i], 32'h0, 5'd7, 32'h0102F3F4, 1, 0);
            n_total++;
            if (o_data !== tbl_exp[i] || o_rd !== 5'd7 || o_rsp_k !== 2 || o_we !== 4'h0 || o_addr !== 32'h100)
                $display("FAIL load_%0d: got data=%h rd=%0d rsp_k=%0d we=%h addr=%h, need %h 7 2 0 00000100",
                         i, o_data, o_rd, o_rsp_k, o_we, o_addr, tbl_exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_misalign();
        run_op(1, 0, 0, DW, 32'h101, 32'h0, 5'd3, 32'h0, 1, 0);
        n_total++;
        if (o_mis !== 1'b1 || o_rsp_k !== 0 || o_en_cnt !== 0 || o_rd !== 5'd0 || o_data !== 32'd0)
            $display("FAIL lw_misalign: got mis=%b rsp_k=%0d en_cnt=%0d rd=%0d data=%h, need 1 0 0 0 0",
                     o_mis, o_rsp_k, o_en_cnt, o_rd, o_data);
        else n_pass++;
        run_op(1, 0, 1, DH, 32'h103, 32'h0, 5'd3, 32'h0, 1, 0);
        n_total++;
        if (o_mis !== 1'b1 || o_rsp_k !== 0 || o_en_cnt !== 0)
            $display("FAIL lh_misalign: got mis=%b rsp_k=%0d en_cnt=%0d, need 1 0 0", o_mis, o_rsp_k, o_en_cnt);
        else n_pass++;
        run_op(0, 0, 0, DW, 32'h101, 32'h0, 5'd9, 32'h0, 1, 0);
        n_total++;
        if (o_mis !== 1'b0 || o_err !== 1'b0 || o_rsp_k !== 0 || o_en_cnt !== 0 || o_rd !== 5'd0)
            $display("FAIL no_op: got mis=%b err=%b rsp_k=%0d en_cnt=%0d rd=%0d, need 0 0 0 0 0",
                     o_mis, o_err, o_rsp_k, o_en_cnt, o_rd);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        run_op(1, 0, 0, DW, 32'h200, 32'h0, 5'd11, 32'hCAFEBABE, 2, 5);
        n_total++;
        if (o_stable !== 1'b1 || o_ready_low !== 1'b1 || o_data !== 32'hCAFEBABE || o_rsp_k !== 3)
            $display("FAIL backpressure: got stable=%b ready_low=%b data=%h rsp_k=%0d, need 1 1 cafebabe 3",
                     o_stable, o_ready_low, o_data, o_rsp_k);
        else n_pass++;
    endtask

    task automatic test_timeout();
        run_op(1, 0, 0, DW, 32'h300, 32'h0, 5'd12, 32'h12345678, 0, 0);
        n_total++;
        if (o_err !== 1'b1 || o_rsp_k !== TO + 1 || o_data !== 32'd0 || o_rd !== 5'd0 || o_mis !== 1'b0)
            $display("FAIL timeout: got err=%b rsp_k=%0d data=%h rd=%0d mis=%b, need 1 %0d 0 0 0",
                     o_err, o_rsp_k, o_data, o_rd, o_mis, TO + 1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int a0;
        run_op(0, 1, 0, DW, 32'h400, 32'h11111111, 5'd1, 32'h0, 1, 0);
        a0 = o_acc;
        run_op(0, 1, 0, DH, 32'h402, 32'h00002222, 5'd1, 32'h0, 1, 0);
        n_total++;
        if (o_acc - a0 !== 3 || o_we !== 4'b1100 || o_wdata !== 32'h22222222)
            $display("FAIL back_to_back: got spacing=%0d we=%b wdata=%h, need 3 1100 22222222",
                     o_acc - a0, o_we, o_wdata);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen;
        req_load = 1; req_store = 0; req_dw = DW; req_addr = 32'h500; req_rd = 5'd4; req_valid = 1'b1;
        while (!req_ready) step();
        step();
        req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        n_total++;
        if (mem_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0)
            $display("FAIL reset_mid: got en=%b rsp_valid=%b ready=%b, need 0 0 0", mem_en, rsp_valid, req_ready);
        else n_pass++;
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        mem_rvalid = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) seen++;
            step();
        end
        n_total++;
        if (seen !== 0)
            $display("FAIL late_rvalid: got %0d rsp_valid cycles, need 0", seen);
        else n_pass++;
        run_op(1, 0, 0, DW, 32'h504, 32'h0, 5'd8, 32'h55AA00FF, 1, 0);
        n_total++;
        if (o_data !== 32'h55AA00FF || o_rd !== 5'd8 || o_rsp_k !== 2 || o_err !== 1'b0)
            $display("FAIL after_reset_lw: got data=%h rd=%0d rsp_k=%0d err=%b, need 55aa00ff 8 2 0",
                     o_data, o_rd, o_rsp_k, o_err);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic l, s, sg, ld, st, mis;
            logic [1:0] dw;
            logic [31:0] addr, w, rdata;
            logic [4:0] rd;
            int nb, off, lat, hold, e_rsp_k;
            l = 1'($urandom); s = 1'($urandom); sg = 1'($urandom);
            dw = 2'($urandom_range(0, 2));
            addr = 32'h1000 + ($urandom & 32'hFF);
            w = $urandom; rdata = $urandom; rd = 5'($urandom_range(1, 31));
            lat = $urandom_range(1, 3); hold = $urandom_range(0, 2);
            nb = 1 << dw; off = addr % 4;
            ld = l; st = s && !l;
            mis = (ld || st) && (addr % nb != 0);
            e_rsp_k = (mis || !(ld || st)) ? 0 : st ? 1 : 1 + lat;
            run_op(l, s, sg, dw, addr, w, rd, rdata, lat, hold);
            n_total++;
            if (o_rsp_k !== e_rsp_k || o_en_cnt !== ((mis || !(ld || st)) ? 0 : 1) || o_stable !== 1'b1)
                $display("FAIL rand_%0d_timing: got rsp_k=%0d en_cnt=%0d stable=%b, need %0d",
                         i, o_rsp_k, o_en_cnt, o_stable, e_rsp_k);
            else n_pass++;
            n_total++;
            if (o_mis !== mis || o_err !== 1'b0 || o_rd !== (ld && !mis ? rd : 5'd0)
                || o_data !== (ld && !mis ? m_load(rdata, nb, sg, off) : 32'd0))
                $display("FAIL rand_%0d_rsp: got mis=%b err=%b rd=%0d data=%h, need mis=%b data=%h",
                         i, o_mis, o_err, o_rd, o_data, mis, ld && !mis ? m_load(rdata, nb, sg, off) : 32'd0);
            else n_pass++;
            if (o_en_k >= 0) begin
                n_total++;
                if (o_addr !== (addr & ~32'h3) || o_we !== (st ? m_we(nb, off) : 4'h0)
                    || (st && o_wdata !== m_wdata(w, nb)))
                    $display("FAIL rand_%0d_mem: got addr=%h we=%b wdata=%h, need %h %b %h", i, o_addr, o_we,
                             o_wdata, addr & ~32'h3, st ? m_we(nb, off) : 4'h0, m_wdata(w, nb));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_loads();
        test_misalign();
        test_backpressure();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
